// File: rtl/sys_bus_initiator_pkg.sv
// Shared definitions for the system-bus initiator: FSM state encoding and the
// 69-bit command word layout stored in the command FIFO.
package sys_bus_initiator_pkg;

    localparam int CMD_W         = 69;
    localparam int CMD_STRB_LSB  = 0;
    localparam int CMD_DATA_LSB  = 4;
    localparam int CMD_ADDR_LSB  = 36;
    localparam int CMD_WRITE_BIT = 68;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;

    // Field order matches the offset constants above (MSB first).
    typedef struct packed {
        logic        write;
        logic [31:0] address;
        logic [31:0] data;
        logic [3:0]  strobe;
    } cmd_t;

    function automatic logic [CMD_W-1:0] pack_cmd(
        input logic        write,
        input logic [31:0] address,
        input logic [31:0] data,
        input logic [3:0]  strobe
    );
        logic [CMD_W-1:0] word;
        word = '0;
        word[CMD_WRITE_BIT]                 = write;
        word[CMD_ADDR_LSB +: 32]            = address;
        word[CMD_DATA_LSB +: 32]            = data;
        word[CMD_STRB_LSB +: 4]             = strobe;
        return word;
    endfunction

endpackage

// File: rtl/sys_bus_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO for initiator commands; the head
// entry is readable combinationally so the FSM can issue it on the pop edge.
module sys_bus_cmd_fifo
    import sys_bus_initiator_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CMD_W
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // One extra pointer bit distinguishes full from empty when indices match.
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sys_bus_initiator.sv
// Queued single-word read/write host agent for the system bus, one transaction
// in flight. Optional request watchdog enabled by SYS_BUS_INITIATOR_TIMEOUT_EN.
module sys_bus_initiator
    import sys_bus_initiator_pkg::*;
#(
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_address,
    input  logic [31:0] cmd_write_data,
    input  logic [3:0]  cmd_write_strobe,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_read_data,
    output logic        rsp_error,
    output logic [31:0] rw_address,
    input  logic [31:0] read_data,
    output logic        read_request,
    input  logic        read_response,
    output logic [31:0] write_data,
    output logic [3:0]  write_strobe,
    output logic        write_request,
    input  logic        write_response
);

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [CMD_W-1:0] head_bits;
    cmd_t             head;

    sys_bus_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk         (clock),
        .srst        (reset),
        .push_i      (cmd_valid),
        .push_data_i (pack_cmd(cmd_write, cmd_address, cmd_write_data, cmd_write_strobe)),
        .pop_i       (fifo_pop),
        .pop_data_o  (head_bits),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign head      = cmd_t'(head_bits);
    assign cmd_ready = !fifo_full;

    logic [1:0]  state_q, state_d;
    logic [31:0] rw_address_q, rw_address_d;
    logic [31:0] write_data_q, write_data_d;
    logic [3:0]  write_strobe_q, write_strobe_d;
    logic        read_request_q, read_request_d;
    logic        write_request_q, write_request_d;
    logic        is_write_q, is_write_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_read_data_q, rsp_read_data_d;
    logic        rsp_error_q, rsp_error_d;
    logic        match;

    assign match = is_write_q ? write_response : read_response;

`ifdef SYS_BUS_INITIATOR_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_count_q, to_count_d;
`else
    // Watchdog compiled out: REQ waits for the device indefinitely.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d         = state_q;
        rw_address_d    = rw_address_q;
        write_data_d    = write_data_q;
        write_strobe_d  = write_strobe_q;
        read_request_d  = read_request_q;
        write_request_d = write_request_q;
        is_write_d      = is_write_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_read_data_d = rsp_read_data_q;
        rsp_error_d     = rsp_error_q;
        fifo_pop        = 1'b0;
`ifdef SYS_BUS_INITIATOR_TIMEOUT_EN
        to_count_d      = to_count_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !rsp_valid_q) begin
                    fifo_pop        = 1'b1;
                    rw_address_d    = head.address;
                    write_data_d    = head.data;
                    write_strobe_d  = head.strobe;
                    is_write_d      = head.write;
                    read_request_d  = !head.write;
                    write_request_d = head.write;
                    state_d         = ST_REQ;
`ifdef SYS_BUS_INITIATOR_TIMEOUT_EN
                    to_count_d      = '0;
`endif
                end
            end
            ST_REQ: begin
                // A matching response beats a simultaneous timeout.
                if (match) begin
                    read_request_d  = 1'b0;
                    write_request_d = 1'b0;
                    rsp_valid_d     = 1'b1;
                    rsp_read_data_d = is_write_q ? 32'h0 : read_data;
                    rsp_error_d     = 1'b0;
                    state_d         = ST_RSP;
                end
`ifdef SYS_BUS_INITIATOR_TIMEOUT_EN
                else begin
                    to_count_d = to_count_q + 1'b1;
                    if (to_count_d == TO_W'(TIMEOUT_CYCLES)) begin
                        read_request_d  = 1'b0;
                        write_request_d = 1'b0;
                        rsp_valid_d     = 1'b1;
                        rsp_read_data_d = 32'h0;
                        rsp_error_d     = 1'b1;
                        state_d         = ST_RSP;
                    end
                end
`endif
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            rw_address_q    <= '0;
            write_data_q    <= '0;
            write_strobe_q  <= '0;
            read_request_q  <= 1'b0;
            write_request_q <= 1'b0;
            is_write_q      <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_read_data_q <= '0;
            rsp_error_q     <= 1'b0;
`ifdef SYS_BUS_INITIATOR_TIMEOUT_EN
            to_count_q      <= '0;
`endif
        end else begin
            state_q         <= state_d;
            rw_address_q    <= rw_address_d;
            write_data_q    <= write_data_d;
            write_strobe_q  <= write_strobe_d;
            read_request_q  <= read_request_d;
            write_request_q <= write_request_d;
            is_write_q      <= is_write_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_read_data_q <= rsp_read_data_d;
            rsp_error_q     <= rsp_error_d;
`ifdef SYS_BUS_INITIATOR_TIMEOUT_EN
            to_count_q      <= to_count_d;
`endif
        end
    end

    assign rw_address    = rw_address_q;
    assign write_data    = write_data_q;
    assign write_strobe  = write_strobe_q;
    assign read_request  = read_request_q;
    assign write_request = write_request_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_read_data = rsp_read_data_q;
`ifdef SYS_BUS_INITIATOR_TIMEOUT_EN
    assign rsp_error     = rsp_error_q;
`else
    assign rsp_error     = 1'b0;
`endif

endmodule

// File: tb/tb_sys_bus_initiator.sv
// Self-checking bench for sys_bus_initiator: bus-side RAM device model plus a
// command-level scoreboard of expected responses.
`timescale 1ns/1ps
module tb_sys_bus_initiator;

    localparam int CMD_DEPTH      = 4;
    localparam int TIMEOUT_CYCLES = 16;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_address;
    logic [31:0] cmd_write_data;
    logic [3:0]  cmd_write_strobe;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_read_data;
    logic        rsp_error;
    logic [31:0] rw_address;
    logic [31:0] read_data;
    logic        read_request;
    logic        read_response;
    logic [31:0] write_data;
    logic [3:0]  write_strobe;
    logic        write_request;
    logic        write_response;

    sys_bus_initiator #(
        .CMD_DEPTH      (CMD_DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_write        (cmd_write),
        .cmd_address      (cmd_address),
        .cmd_write_data   (cmd_write_data),
        .cmd_write_strobe (cmd_write_strobe),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_read_data    (rsp_read_data),
        .rsp_error        (rsp_error),
        .rw_address       (rw_address),
        .read_data        (read_data),
        .read_request     (read_request),
        .read_response    (read_response),
        .write_data       (write_data),
        .write_strobe     (write_strobe),
        .write_request    (write_request),
        .write_response   (write_response)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int n_rsp    = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] dev_mem [logic [31:0]];
    bit          dev_en      = 1'b1;
    int          dev_max_lat = 0;
    bit          stray_wr    = 1'b0;

    function automatic bit is_mapped(input logic [31:0] a);
        return a < 32'h4000_0000;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] d,
                                                input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    // Scoreboard: commands complete in order, so expectations are fixed at accept time.
    task automatic model_accept(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s);
        exp_t e;
        logic [31:0] old;
        old = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
        if (w) begin
            ref_mem[a] = merge_bytes(old, d, s);
            e.data = 32'h0;
            e.err  = 1'b0;
        end else if (!is_mapped(a)) begin
            e.data = 32'h0;
            e.err  = 1'b1;
        end else begin
            e.data = old;
            e.err  = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    // RAM device on the host port: random latency, unmapped addresses never answer.
    initial begin
        int wait_cnt;
        wait_cnt       = -1;
        read_response  = 1'b0;
        write_response = 1'b0;
        read_data      = 32'h0;
        forever begin
            @(negedge clock);
            read_response  = 1'b0;
            write_response = 1'b0;
            read_data      = $urandom();
            if (stray_wr) begin
                write_response = 1'b1;
                stray_wr       = 1'b0;
            end
            if (dev_en && !reset && (read_request || write_request) && is_mapped(rw_address)) begin
                if (wait_cnt < 0) wait_cnt = $urandom_range(dev_max_lat, 0);
                if (wait_cnt == 0) begin
                    if (write_request) begin
                        write_response = 1'b1;
                        dev_mem[rw_address] = merge_bytes(
                            dev_mem.exists(rw_address) ? dev_mem[rw_address] : 32'h0,
                            write_data, write_strobe);
                    end else begin
                        read_response = 1'b1;
                        read_data = dev_mem.exists(rw_address) ? dev_mem[rw_address] : 32'h0;
                    end
                    wait_cnt = -1;
                end else begin
                    wait_cnt--;
                end
            end else begin
                wait_cnt = -1;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        bit accepted;
        accepted         = 1'b0;
        cmd_write        = w;
        cmd_address      = a;
        cmd_write_data   = d;
        cmd_write_strobe = s;
        cmd_valid        = 1'b1;
        for (int i = 0; i < 300 && !accepted; i++) begin
            if (cmd_ready) begin
                @(posedge clock);
                model_accept(w, a, d, s);
                accepted = 1'b1;
            end
            @(negedge clock);
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (!accepted) begin
            n_fail++;
            $display("FAIL cmd_accept: cmd_ready=%0b, required accept within 300 cycles", cmd_ready);
        end
    endtask

    // Consumes n responses with rsp_ready asserted ready_pct percent of cycles.
    task automatic wait_responses(input int n, input int ready_pct);
        int got;
        exp_t e;
        got = 0;
        for (int cyc = 0; cyc < 3000 && got < n; cyc++) begin
            rsp_ready = ($urandom_range(99, 0) < ready_pct);
            if (rsp_valid && rsp_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected: data=%h err=%0b, required no response", rsp_read_data, rsp_error);
                end else begin
                    e = exp_q.pop_front();
                    n_rsp++;
                    $display("rsp %0d: data=%h err=%0b", n_rsp, rsp_read_data, rsp_error);
                    if (rsp_read_data !== e.data || rsp_error !== e.err) begin
                        n_fail++;
                        $display("FAIL rsp_fields: data=%h err=%0b, required data=%h err=%0b",
                                 rsp_read_data, rsp_error, e.data, e.err);
                    end
                end
                got++;
            end
            @(negedge clock);
        end
        rsp_ready = 1'b0;
        n_checks++;
        if (got != n) begin
            n_fail++;
            $display("FAIL rsp_count: got %0d responses, required %0d", got, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_cmd_ready: got %0b, required 1", cmd_ready);
        end
        n_checks++;
        if ({rsp_valid, rsp_error, read_request, write_request} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b, required 0000",
                               {rsp_valid, rsp_error, read_request, write_request});
        end
        n_checks++;
        if ({rw_address, write_data, write_strobe, rsp_read_data} !== 100'h0) begin
            n_fail++; $display("FAIL reset_data: addr=%h wdata=%h strb=%h rdata=%h, required all 0",
                               rw_address, write_data, write_strobe, rsp_read_data);
        end
    endtask

    task automatic test_write_read();
        dev_en = 1'b1; dev_max_lat = 0; rsp_ready = 1'b0;
        send_cmd(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        @(negedge clock);
        n_checks++;
        if (write_request !== 1'b1 || read_request !== 1'b0 || rw_address !== 32'h10 ||
            write_data !== 32'hDEAD_BEEF || write_strobe !== 4'hF) begin
            n_fail++;
            $display("FAIL write_issue: wreq=%0b rreq=%0b addr=%h data=%h strb=%h, required 1 0 00000010 deadbeef f",
                     write_request, read_request, rw_address, write_data, write_strobe);
        end
        send_cmd(1'b0, 32'h10, 32'h0, 4'h0);
        wait_responses(2, 100);
    endtask

    task automatic test_fifo_full();
        dev_en = 1'b1; dev_max_lat = 0; rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_cmd(1'($urandom_range(1, 0)), 32'($urandom_range(15, 0)), $urandom(), 4'($urandom_range(15, 0)));
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (cmd_ready !== 1'b0) begin
                n_fail++; $display("FAIL fifo_full_ready: cycle %0d got %0b, required 0", i, cmd_ready);
            end
            @(negedge clock);
        end
        wait_responses(5, 100);
    endtask

    task automatic test_backpressure();
        bit seen;
        dev_en = 1'b1; dev_max_lat = 2; rsp_ready = 1'b0;
        send_cmd(1'b0, 32'h10, 32'h0, 4'h0);
        send_cmd(1'b1, 32'h20, $urandom(), 4'hF);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (rsp_valid) seen = 1'b1;
            else @(negedge clock);
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL bp_rsp_timeout: rsp_valid=%0b, required 1 within 50 cycles", rsp_valid);
        end
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_read_data !== exp_q[0].data || rsp_error !== exp_q[0].err ||
                read_request !== 1'b0 || write_request !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: valid=%0b data=%h err=%0b rreq=%0b wreq=%0b, required 1 %h %0b 0 0",
                         rsp_valid, rsp_read_data, rsp_error, read_request, write_request,
                         exp_q[0].data, exp_q[0].err);
            end
            @(negedge clock);
        end
        wait_responses(2, 100);
    endtask

    task automatic test_stray();
        dev_en = 1'b0; rsp_ready = 1'b0;
        send_cmd(1'b0, 32'h10, 32'h0, 4'h0);
        @(posedge clock); #1;
        stray_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_checks++;
            if (rsp_valid !== 1'b0 || read_request !== 1'b1) begin
                n_fail++; $display("FAIL stray_ignored: valid=%0b rreq=%0b, required 0 1", rsp_valid, read_request);
            end
        end
        dev_en = 1'b1; dev_max_lat = 0;
        wait_responses(1, 100);
    endtask

`ifdef SYS_BUS_INITIATOR_TIMEOUT_EN
    task automatic test_timeout();
        int high_cycles;
        bit done;
        dev_en = 1'b1; rsp_ready = 1'b0;
        send_cmd(1'b0, 32'h4000_0000, 32'h0, 4'h0);
        high_cycles = 0;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (rsp_valid) done = 1'b1;
            else begin
                if (read_request) high_cycles++;
                @(negedge clock);
            end
        end
        n_checks++;
        if (high_cycles != TIMEOUT_CYCLES || !done) begin
            n_fail++; $display("FAIL timeout_len: request high %0d cycles, required %0d", high_cycles, TIMEOUT_CYCLES);
        end
        n_checks++;
        if (rsp_error !== 1'b1 || rsp_read_data !== 32'h0 || read_request !== 1'b0) begin
            n_fail++; $display("FAIL timeout_rsp: err=%0b data=%h rreq=%0b, required 1 00000000 0",
                               rsp_error, rsp_read_data, read_request);
        end
        wait_responses(1, 100);
    endtask
`endif

    task automatic test_reset_mid();
        dev_en = 1'b0; rsp_ready = 1'b0;
        send_cmd(1'b0, 32'h10, 32'h0, 4'h0);
        send_cmd(1'b0, 32'h11, 32'h0, 4'h0);
        send_cmd(1'b0, 32'h12, 32'h0, 4'h0);
        n_checks++;
        if (read_request !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre: rreq=%0b, required 1", read_request);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_checks++;
        if (read_request !== 1'b0 || write_request !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_drop: rreq=%0b wreq=%0b ready=%0b, required 0 0 1",
                               read_request, write_request, cmd_ready);
        end
        exp_q.delete();
        dev_en = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            n_checks++;
            if (rsp_valid !== 1'b0 || read_request !== 1'b0) begin
                n_fail++; $display("FAIL rstmid_quiet: valid=%0b rreq=%0b, required 0 0", rsp_valid, read_request);
            end
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        dev_en = 1'b1; dev_max_lat = 3;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send_cmd(1'($urandom_range(1, 0)), 32'($urandom_range(31, 0)), $urandom(),
                             4'($urandom_range(15, 0)));
                end
            end
            begin
                wait_responses(40, 60);
            end
        join
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0;
        cmd_write_data = '0; cmd_write_strobe = '0; rsp_ready = 1'b0;
        @(negedge clock);
        test_reset();
        test_write_read();
        test_fifo_full();
        test_backpressure();
        test_stray();
`ifdef SYS_BUS_INITIATOR_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        test_random();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL leftover_rsp: %0d outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_watchdog: simulation still running at 2 ms, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
